// File: rtl/hazard_ctrl_if.sv
// Control bundle between the five-stage core and hazard_ctrl.
// Optional HAZARD_PERF_EN adds the three performance counter outputs.
interface hazard_ctrl_if;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_uses_rs1;
  logic        ifid_uses_rs2;
  logic [4:0]  idex_rd;
  logic        idex_mem_read;
  logic        ex_redirect;
  logic        imem_req;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_resp;
  logic        pc_ld;
  logic        ifid_ld;
  logic        idex_ld;
  logic        exmem_ld;
  logic        memwb_ld;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_freeze_cycles;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushes;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_mem_read,
           ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    input  pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush, state,
           perf_freeze_cycles, perf_bubbles, perf_flushes
  );
  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_mem_read,
           ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    output pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush, state,
           perf_freeze_cycles, perf_bubbles, perf_flushes
  );
`else
  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_mem_read,
           ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    input  pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush, state
  );
  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_mem_read,
           ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    output pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush, state
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline freeze / load-use bubble / redirect squash controller for the RV32I core.
// Define HAZARD_PERF_EN to add saturating freeze, bubble and flush counters.
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   imem_done;
  logic   dmem_done;
  logic   imem_done_d;
  logic   dmem_done_d;
  logic   mem_ok_i;
  logic   mem_ok_d;
  logic   advance;
  logic   lu;

  // A response arriving while the other port stalls is remembered until the advancing edge.
  always_comb begin
    mem_ok_i = !bus.imem_req || bus.imem_resp || imem_done;
    mem_ok_d = !bus.dmem_req || bus.dmem_resp || dmem_done;
    advance  = mem_ok_i && mem_ok_d;
    lu = bus.idex_mem_read && (bus.idex_rd != 5'd0) &&
         ((bus.ifid_uses_rs1 && (bus.ifid_rs1 == bus.idex_rd)) ||
          (bus.ifid_uses_rs2 && (bus.ifid_rs2 == bus.idex_rd)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      imem_done <= imem_done_d;
      dmem_done <= dmem_done_d;
    end
  end

  always_comb begin
    state_d        = RUN;
    imem_done_d    = 1'b0;
    dmem_done_d    = 1'b0;
    bus.pc_ld      = 1'b1;
    bus.ifid_ld    = 1'b1;
    bus.idex_ld    = 1'b1;
    bus.exmem_ld   = 1'b1;
    bus.memwb_ld   = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    if (!advance) begin
      state_d        = FREEZE;
      imem_done_d    = imem_done || (bus.imem_req && bus.imem_resp);
      dmem_done_d    = dmem_done || (bus.dmem_req && bus.dmem_resp);
      bus.pc_ld      = 1'b0;
      bus.ifid_ld    = 1'b0;
      bus.idex_ld    = 1'b0;
      bus.exmem_ld   = 1'b0;
      bus.memwb_ld   = 1'b0;
    end else if (bus.ex_redirect) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (lu) begin
      state_d        = BUBBLE;
      bus.pc_ld      = 1'b0;
      bus.ifid_ld    = 1'b0;
      bus.idex_flush = 1'b1;
    end
    // Hold every pipeline register while reset is asserted.
    if (!rst_n) begin
      bus.pc_ld      = 1'b0;
      bus.ifid_ld    = 1'b0;
      bus.idex_ld    = 1'b0;
      bus.exmem_ld   = 1'b0;
      bus.memwb_ld   = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_flush = 1'b0;
    end
  end

  assign bus.state = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] freeze_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_cnt <= 32'd0;
      bubble_cnt <= 32'd0;
      flush_cnt  <= 32'd0;
    end else begin
      if (!advance && freeze_cnt != 32'hFFFF_FFFF)
        freeze_cnt <= freeze_cnt + 32'd1;
      if (advance && !bus.ex_redirect && lu && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (advance && bus.ex_redirect && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.perf_freeze_cycles = freeze_cnt;
  assign bus.perf_bubbles       = bubble_cnt;
  assign bus.perf_flushes       = flush_cnt;
`endif

endmodule
